// File: rtl/mem_responder.sv
// Single-port 64-bit memory responder with level-held read/write requests and ok pulses.
// Define MEM_RESPONDER_MISALIGN_EN to split unaligned accesses into two beats.
module mem_responder #(
  parameter int DEPTH_LOG2 = 12,
  parameter int LATENCY    = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ren,
  input  logic [63:0] raddr,
  output logic [63:0] rdata,
  output logic        sig_memread_ok,
  input  logic        wen,
  input  logic [63:0] waddr,
  input  logic [63:0] wdata,
  input  logic [63:0] wmask,
  output logic        sig_memwrite_ok
);

  localparam int AW    = DEPTH_LOG2 + 3;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    BEAT0 = 3'd2,
    BEAT1 = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  op_wr_q, op_wr_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [63:0]           wdata_q, wdata_d;
  logic [63:0]           wmask_q, wmask_d;
  logic [63:0]           word0_q, word0_d;
  logic [63:0]           rdata_q, rdata_d;
  logic                  rok_q, rok_d;
  logic                  wok_q, wok_d;

  logic [63:0]           mem [DEPTH];
  logic [2:0]            off;
  logic [6:0]            sh;
  logic [DEPTH_LOG2-1:0] idx0, idx1;
  logic [127:0]          mask_sh, data_sh, rd_cat;
  logic                  mem_we;
  logic [DEPTH_LOG2-1:0] mem_widx;
  logic [63:0]           mem_wmask, mem_wdata;
  logic                  unused_bits;

`ifdef MEM_RESPONDER_MISALIGN_EN
  assign off = addr_q[2:0];
`else
  assign off = 3'd0;
`endif

  // Address bits above the store are aliased away; low bits only matter when split beats exist.
  assign unused_bits = ^{raddr[63:AW], waddr[63:AW], addr_q[2:0]};

  assign sh      = {1'b0, off, 3'b000};
  assign idx0    = addr_q[AW-1:3];
  assign idx1    = idx0 + DEPTH_LOG2'(1);
  assign mask_sh = {64'b0, wmask_q} << sh;
  assign data_sh = {64'b0, wdata_q} << sh;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_wr_d   = op_wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wmask_d   = wmask_q;
    word0_d   = word0_q;
    rdata_d   = rdata_q;
    rok_d     = 1'b0;
    wok_d     = 1'b0;
    mem_we    = 1'b0;
    mem_widx  = idx0;
    mem_wmask = mask_sh[63:0];
    mem_wdata = data_sh[63:0];
    rd_cat    = '0;
    case (state_q)
      IDLE: begin
        if (ren) begin
          op_wr_d = 1'b0;
          addr_d  = raddr[AW-1:0];
          cnt_d   = 4'(LATENCY);
          state_d = (LATENCY > 0) ? WAIT : BEAT0;
        end else if (wen) begin
          op_wr_d = 1'b1;
          addr_d  = waddr[AW-1:0];
          wdata_d = wdata;
          wmask_d = wmask;
          cnt_d   = 4'(LATENCY);
          state_d = (LATENCY > 0) ? WAIT : BEAT0;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = BEAT0;
      end
      BEAT0: begin
        if (op_wr_q) begin
          mem_we = 1'b1;
          if (|mask_sh[127:64]) begin
            state_d = BEAT1;
          end else begin
            state_d = DONE;
            wok_d   = 1'b1;
          end
        end else if (off != 3'd0) begin
          word0_d = mem[idx0];
          state_d = BEAT1;
        end else begin
          rdata_d = mem[idx0];
          state_d = DONE;
          rok_d   = 1'b1;
        end
      end
      BEAT1: begin
        state_d = DONE;
        if (op_wr_q) begin
          mem_we    = 1'b1;
          mem_widx  = idx1;
          mem_wmask = mask_sh[127:64];
          mem_wdata = data_sh[127:64];
          wok_d     = 1'b1;
        end else begin
          rd_cat  = {mem[idx1], word0_q} >> sh;
          rdata_d = rd_cat[63:0];
          rok_d   = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      word0_q <= '0;
      rdata_q <= '0;
      rok_q   <= 1'b0;
      wok_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_wr_q <= op_wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      word0_q <= word0_d;
      rdata_q <= rdata_d;
      rok_q   <= rok_d;
      wok_q   <= wok_d;
    end
  end

  // Store is never reset, so a beat committed before an abort survives it.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_widx] <= (mem[mem_widx] & ~mem_wmask) | (mem_wdata & mem_wmask);
  end

  assign rdata           = rdata_q;
  assign sig_memread_ok  = rok_q;
  assign sig_memwrite_ok = wok_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (LATENCY 0 and 3, 16-word store) against a byte-level model.
module tb_mem_responder;
`ifdef MEM_RESPONDER_MISALIGN_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_s   [2];
  logic        ren_s   [2];
  logic        wen_s   [2];
  logic [63:0] raddr_s [2];
  logic [63:0] waddr_s [2];
  logic [63:0] wdata_s [2];
  logic [63:0] wmask_s [2];
  logic [63:0] rdata_w [2];
  logic        rok_w   [2];
  logic        wok_w   [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_responder #(.DEPTH_LOG2(4), .LATENCY((g == 0) ? 0 : 3)) u_dut (
      .clk            (clk),
      .rst            (rst_s[g]),
      .ren            (ren_s[g]),
      .raddr          (raddr_s[g]),
      .rdata          (rdata_w[g]),
      .sig_memread_ok (rok_w[g]),
      .wen            (wen_s[g]),
      .waddr          (waddr_s[g]),
      .wdata          (wdata_s[g]),
      .wmask          (wmask_s[g]),
      .sig_memwrite_ok(wok_w[g])
    );
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [63:0] mem_m  [2][16];
  logic [63:0] rd_old [2];
  logic [63:0] rd_new [2];
  int          rd_at  [2];
  int          wr_at  [2];
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int lat_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic int byte_addr(input logic [63:0] a, input int k);
    int base;
    base = MIS ? int'(a[6:0]) : int'({a[6:3], 3'b000});
    return (base + k) % 128;
  endfunction

  function automatic logic [63:0] model_read(input int d, input logic [63:0] a);
    logic [63:0] r;
    int b;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      b = byte_addr(a, k);
      r[8*k +: 8] = mem_m[d][b/8][8*(b%8) +: 8];
    end
    return r;
  endfunction

  function automatic void model_write(input int d, input logic [63:0] a, input logic [63:0] wd,
                                      input logic [63:0] wm, input bit lo_only);
    int b;
    logic [7:0] m8, old;
    for (int k = 0; k < 8; k++) begin
      if (!lo_only || (int'(a[2:0]) + k < 8)) begin
        b   = byte_addr(a, k);
        m8  = wm[8*k +: 8];
        old = mem_m[d][b/8][8*(b%8) +: 8];
        mem_m[d][b/8][8*(b%8) +: 8] = (old & ~m8) | (wd[8*k +: 8] & m8);
      end
    end
  endfunction

  function automatic bit rd_two(input logic [63:0] a);
    return MIS && (a[2:0] != 3'd0);
  endfunction

  function automatic bit wr_two(input logic [63:0] a, input logic [63:0] m);
    bit r;
    r = 1'b0;
    if (MIS)
      for (int k = 0; k < 8; k++)
        if ((int'(a[2:0]) + k >= 8) && (m[8*k +: 8] != 8'h00)) r = 1'b1;
    return r;
  endfunction

  task automatic wait_ok(input int d, input bit isrd, output int s);
    bit seen;
    seen = 1'b0;
    s = -1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (isrd ? rok_w[d] : wok_w[d]) begin
        seen = 1'b1;
        s = cyc;
      end
    end
    check($sformatf("ok_seen dut%0d rd%0d", d, isrd), 64'(seen), 64'd1);
    @(posedge clk); #1;
  endtask

  // Issue a read, a write, or both at once; returns observed request-to-ok latencies.
  task automatic access(input int d, input bit rd, input bit wr, input logic [63:0] ra,
                        input logic [63:0] wa, input logic [63:0] wd, input logic [63:0] wm,
                        output int lr_obs, output int lw_obs);
    int a, aw, lr, lw, s;
    lr_obs = 0; lw_obs = 0; lr = 0; lw = 0; aw = 0;
    ren_s[d] = rd; wen_s[d] = wr;
    raddr_s[d] = ra; waddr_s[d] = wa; wdata_s[d] = wd; wmask_s[d] = wm;
    a = cyc + 1;
    if (rd) begin
      lr = lat_of(d) + 2 + (rd_two(ra) ? 1 : 0);
      rd_old[d] = rd_new[d];
      rd_new[d] = model_read(d, ra);
      rd_at[d]  = a + lr - 1;
    end
    if (wr) begin
      aw = rd ? a + lr + 1 : a;
      lw = lat_of(d) + 2 + (wr_two(wa, wm) ? 1 : 0);
      wr_at[d] = aw + lw - 1;
    end
    @(posedge clk); #1;
    if (rd) begin
      raddr_s[d] = {$urandom, $urandom};
      wait_ok(d, 1'b1, s);
      lr_obs = s + 1 - a;
      ren_s[d] = 1'b0;
    end
    if (wr) begin
      if (rd) begin @(posedge clk); #1; end
      waddr_s[d] = {$urandom, $urandom};
      wdata_s[d] = {$urandom, $urandom};
      wmask_s[d] = {$urandom, $urandom};
      model_write(d, wa, wd, wm, 1'b0);
      wait_ok(d, 1'b0, s);
      lw_obs = s + 1 - aw;
      wen_s[d] = 1'b0;
    end
  endtask

  initial begin
    int lr, lw, a;
    logic [63:0] ra, wa, wd, wm;
    for (int d = 0; d < 2; d++) begin
      rst_s[d] = 1'b1; ren_s[d] = 1'b0; wen_s[d] = 1'b0;
      raddr_s[d] = '0; waddr_s[d] = '0; wdata_s[d] = '0; wmask_s[d] = '0;
      rd_old[d] = '0; rd_new[d] = '0; rd_at[d] = -1; wr_at[d] = -1;
    end
    fork
      forever begin
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
          check($sformatf("rd_ok dut%0d", d), 64'(rok_w[d]), 64'(cyc == rd_at[d]));
          check($sformatf("wr_ok dut%0d", d), 64'(wok_w[d]), 64'(cyc == wr_at[d]));
          check($sformatf("rdata dut%0d", d), rdata_w[d], (cyc >= rd_at[d]) ? rd_new[d] : rd_old[d]);
        end
      end
    join_none
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset rdata dut%0d", d), rdata_w[d], 64'h0);
      check($sformatf("reset ok dut%0d", d), 64'({rok_w[d], wok_w[d]}), 64'h0);
      rst_s[d] = 1'b0;
    end
    @(posedge clk); #1;

    for (int d = 0; d < 2; d++)
      for (int w = 0; w < 16; w++)
        access(d, 1'b0, 1'b1, 64'h0, 64'(w * 8), {$urandom, $urandom}, {64{1'b1}}, lr, lw);

    // Basic aligned write then read, no latency
    access(0, 1'b0, 1'b1, 64'h0, 64'h10, 64'h1122334455667788, {64{1'b1}}, lr, lw);
    check("w32 latency", 64'(lw), 64'd2);
    access(0, 1'b1, 1'b0, 64'h10, 64'h0, 64'h0, 64'h0, lr, lw);
    check("r32 latency", 64'(lr), 64'd2);
    check("r32 rdata", rdata_w[0], 64'h1122334455667788);

    // Unaligned read spanning words 0 and 1
    access(0, 1'b0, 1'b1, 64'h0, 64'h0, 64'h0706050403020100, {64{1'b1}}, lr, lw);
    access(0, 1'b0, 1'b1, 64'h0, 64'h8, 64'h0F0E0D0C0B0A0908, {64{1'b1}}, lr, lw);
    check("model r33", model_read(0, 64'h3), MIS ? 64'h0A09080706050403 : 64'h0706050403020100);
    access(0, 1'b1, 1'b0, 64'h3, 64'h0, 64'h0, 64'h0, lr, lw);
    check("r33 rdata", rdata_w[0], MIS ? 64'h0A09080706050403 : 64'h0706050403020100);
    check("r33 latency", 64'(lr), MIS ? 64'd3 : 64'd2);

    // Masked write at offset 6 that stays in one word
    access(0, 1'b0, 1'b1, 64'h0, 64'h6, 64'hAABB, 64'hFFFF, lr, lw);
    check("w34 latency", 64'(lw), 64'd2);
    access(0, 1'b1, 1'b0, 64'h0, 64'h0, 64'h0, 64'h0, lr, lw);
    check("w34 word0", rdata_w[0], MIS ? 64'hAABB050403020100 : 64'h070605040302AABB);
    access(0, 1'b1, 1'b0, 64'h8, 64'h0, 64'h0, 64'h0, lr, lw);
    check("w34 word1", rdata_w[0], 64'h0F0E0D0C0B0A0908);

    // Wrap from word 15 to word 0, and high-address aliasing
    access(0, 1'b0, 1'b1, 64'h0, 64'h78, 64'hF7F6F5F4F3F2F1F0, {64{1'b1}}, lr, lw);
    check("model r37", model_read(0, 64'h7D), MIS ? 64'h0403020100F7F6F5 : 64'hF7F6F5F4F3F2F1F0);
    access(0, 1'b1, 1'b0, 64'h7D, 64'h0, 64'h0, 64'h0, lr, lw);
    check("r37 rdata", rdata_w[0], MIS ? 64'h0403020100F7F6F5 : 64'hF7F6F5F4F3F2F1F0);
    access(0, 1'b1, 1'b0, 64'hFFFF_0000_0000_0010, 64'h0, 64'h0, 64'h0, lr, lw);
    check("alias rdata", rdata_w[0], 64'h1122334455667788);

    // Simultaneous read and write: read first, write follows
    access(0, 1'b1, 1'b1, 64'h10, 64'h18, 64'h5A5A_A5A5_0F0F_F0F0, {64{1'b1}}, lr, lw);
    check("rw read latency", 64'(lr), 64'd2);
    check("rw write latency", 64'(lw), 64'd2);
    access(0, 1'b1, 1'b0, 64'h18, 64'h0, 64'h0, 64'h0, lr, lw);
    check("rw readback", rdata_w[0], 64'h5A5A_A5A5_0F0F_F0F0);

    // Reset two cycles into a LATENCY=3 read
    access(1, 1'b0, 1'b1, 64'h0, 64'h20, 64'hDEADBEEFCAFEF00D, {64{1'b1}}, lr, lw);
    access(1, 1'b0, 1'b1, 64'h0, 64'h28, 64'h0123456789ABCDEF, {64{1'b1}}, lr, lw);
    access(1, 1'b1, 1'b0, 64'h20, 64'h0, 64'h0, 64'h0, lr, lw);
    check("lat3 latency", 64'(lr), 64'd5);
    ren_s[1] = 1'b1; raddr_s[1] = 64'h28;
    repeat (3) begin @(posedge clk); #1; end
    rst_s[1] = 1'b1; ren_s[1] = 1'b0;
    rd_old[1] = '0; rd_new[1] = '0; rd_at[1] = -1;
    #1;
    check("abort rdata", rdata_w[1], 64'h0);
    check("abort ok", 64'({rok_w[1], wok_w[1]}), 64'h0);
    @(posedge clk); #1;
    rst_s[1] = 1'b0;
    access(1, 1'b1, 1'b0, 64'h20, 64'h0, 64'h0, 64'h0, lr, lw);
    check("post-reset latency", 64'(lr), 64'd5);
    check("post-reset rdata", rdata_w[1], 64'hDEADBEEFCAFEF00D);

    // Reset during the second beat of a split write keeps only the first beat
    if (MIS) begin
      wd = 64'h0000_0000_4433_2211;
      wen_s[1] = 1'b1; waddr_s[1] = 64'h26; wdata_s[1] = wd; wmask_s[1] = 64'hFFFF_FFFF;
      repeat (5) begin @(posedge clk); #1; end
      rst_s[1] = 1'b1; wen_s[1] = 1'b0;
      rd_old[1] = '0; rd_new[1] = '0; rd_at[1] = -1;
      model_write(1, 64'h26, wd, 64'hFFFF_FFFF, 1'b1);
      @(posedge clk); #1;
      rst_s[1] = 1'b0;
      access(1, 1'b1, 1'b0, 64'h20, 64'h0, 64'h0, 64'h0, lr, lw);
      check("partial word4", rdata_w[1], 64'h2211BEEFCAFEF00D);
      access(1, 1'b1, 1'b0, 64'h28, 64'h0, 64'h0, 64'h0, lr, lw);
      check("partial word5", rdata_w[1], 64'h0123456789ABCDEF);
    end

    // Randomized traffic on both instances
    for (int i = 0; i < 150; i++) begin
      int d, kind;
      d    = $urandom_range(0, 1);
      kind = $urandom_range(0, 2);
      ra   = {$urandom, $urandom};
      wa   = {$urandom, $urandom};
      wd   = {$urandom, $urandom};
      wm   = ($urandom_range(0, 3) == 0) ? {64{1'b1}} : {$urandom, $urandom};
      access(d, kind != 1, kind != 0, ra, wa, wd, wm, lr, lw);
    end
    repeat (3) @(posedge clk);
    #1;
    a = n_fail;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, a);
    $finish;
  end

endmodule
